// File: rtl/softmax_div_sched_if.sv
// softmax_div_sched_if: stream, divider and status signals of the softmax divider sequencer.
interface softmax_div_sched_if;
  logic        div_ld;
  logic [31:0] div_val;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        s_last;
  logic        div_en;
  logic [63:0] div_a;
  logic [31:0] div_b;
  logic [63:0] div_quotient;
  logic        div_by_0;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_quotient;
  logic        m_div0;
  logic        m_last;
  logic        busy;
  logic        err_div0;
  modport slave (
    input  div_ld, div_val, s_valid, s_data, s_last, div_quotient, div_by_0, m_ready,
    output s_ready, div_en, div_a, div_b, m_valid, m_quotient, m_div0, m_last, busy, err_div0
  );
  modport master (
    output div_ld, div_val, s_valid, s_data, s_last, div_quotient, div_by_0, m_ready,
    input  s_ready, div_en, div_a, div_b, m_valid, m_quotient, m_div0, m_last, busy, err_div0
  );
endinterface

// File: rtl/softmax_div_sched.sv
// softmax_div_sched: issues dividends into a fixed-latency divider and buffers results in a
// credit-checked FIFO so the divider never has to stall mid-vector.
module softmax_div_sched #(
  parameter int LAT        = 4,
  parameter int FIFO_DEPTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  softmax_div_sched_if.slave sif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t        state_q, state_d;
  logic [LAT:0]  tv_q, tl_q;
  logic [CW-1:0] inflight_q, inflight_d, cnt_q, cnt_d;
  logic [AW-1:0] wp_q, rp_q;
  logic [65:0]   mem_q [FIFO_DEPTH];
  logic [63:0]   div_a_q;
  logic [31:0]   div_b_q;
  logic          err_q;
  logic          ld, credit, acc, wr, pop;
  assign ld          = state_q == IDLE && sif.div_ld;
  // Credit counts every result not yet popped, so a tag exit always finds a free FIFO slot.
  assign credit      = {1'b0, inflight_q} + {1'b0, cnt_q} < (CW + 1)'(FIFO_DEPTH);
  assign sif.s_ready = state_q == RUN && credit;
  assign acc         = sif.s_valid && sif.s_ready;
  assign wr          = tv_q[LAT];
  assign sif.m_valid = cnt_q != '0;
  assign pop         = sif.m_valid && sif.m_ready;
  assign inflight_d  = inflight_q + CW'(acc) - CW'(wr);
  assign cnt_d       = cnt_q + CW'(wr) - CW'(pop);
  assign {sif.m_quotient, sif.m_div0, sif.m_last} = mem_q[rp_q];
  assign sif.div_en   = state_q != IDLE;
  assign sif.busy     = state_q != IDLE;
  assign sif.div_a    = div_a_q;
  assign sif.div_b    = div_b_q;
  assign sif.err_div0 = err_q;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = ld ? RUN : IDLE;
      RUN:     state_d = acc && sif.s_last ? DRAIN : RUN;
      DRAIN:   state_d = inflight_q == '0 && cnt_q == '0 ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tv_q       <= '0;
      tl_q       <= '0;
      inflight_q <= '0;
      cnt_q      <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      div_a_q    <= '0;
      div_b_q    <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      tv_q       <= {tv_q[LAT-1:0], acc};
      tl_q       <= {tl_q[LAT-1:0], acc & sif.s_last};
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      if (acc) div_a_q <= sif.s_data;
      if (ld) begin
        div_b_q <= sif.div_val;
        err_q   <= err_q | (sif.div_val == '0);
      end
      if (wr) begin
        mem_q[wp_q] <= {sif.div_quotient, sif.div_by_0, tl_q[LAT]};
        wp_q        <= wp_q + 1'b1;
      end
      if (pop) rp_q <= rp_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_softmax_div_sched.sv
// tb_softmax_div_sched: random and directed vectors against a result-queue model and a
// behavioural pipelined divider.
module tb_softmax_div_sched;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0, checks = 0, cyc = 0;
  int n_acc = 0, n_pop = 0, n_last = 0, outst_max = 0;
  int first_acc = -1, first_mv = -1, last_pop = -1;
  logic [31:0] vec_div = '0;
  logic [63:0] eq;
  logic [65:0] ex;
  logic [65:0] exp_q[$];
  int          popc_q[$];
  logic        rnd_ready = 1'b0;
  logic [63:0] pq [LAT];
  logic        pz [LAT];

  softmax_div_sched_if sif ();
  softmax_div_sched #(.LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .sif(sif));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pipelined 64/32 divider: sampled on an enabled edge, result visible LAT-1 edges later.
  always @(posedge clk) if (sif.div_en) begin
    pq[0] <= sif.div_b == 32'd0 ? '1 : sif.div_a / 64'(sif.div_b);
    pz[0] <= sif.div_b == 32'd0;
    for (int i = 1; i < LAT; i++) begin
      pq[i] <= pq[i-1];
      pz[i] <= pz[i-1];
    end
  end
  assign sif.div_quotient = pq[LAT-1];
  assign sif.div_by_0     = pz[LAT-1];

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: each accepted dividend queues the quotient the current vector must produce.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (sif.s_valid && sif.s_ready) begin
        eq = vec_div == 32'd0 ? '1 : sif.s_data / 64'(vec_div);
        exp_q.push_back({eq, vec_div == 32'd0, sif.s_last});
        if (first_acc < 0) first_acc = cyc;
        n_acc++;
      end
      if (sif.m_valid && first_mv < 0) first_mv = cyc;
      if (sif.m_valid && sif.m_ready) begin
        if (exp_q.size() == 0) ex = 'x;
        else ex = exp_q.pop_front();
        chk("result", {sif.m_quotient, sif.m_div0, sif.m_last}, ex);
        n_pop++;
        if (sif.m_last) n_last++;
        last_pop = cyc;
        popc_q.push_back(cyc);
      end
      if (n_acc - n_pop > outst_max) outst_max = n_acc - n_pop;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ready) sif.m_ready = 1'($urandom);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear();
    n_acc = 0; n_pop = 0; n_last = 0; outst_max = 0;
    first_acc = -1; first_mv = -1; last_pop = -1;
    popc_q.delete();
  endtask

  task automatic load(input logic [31:0] d);
    vec_div = d;
    sif.div_ld = 1'b1;
    sif.div_val = d;
    tick(1);
    sif.div_ld = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input logic l, input int gap);
    int n = 0;
    tick(gap);
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    sif.s_last  = l;
    @(negedge clk);
    while (!sif.s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", 66'(n >= 200), 66'(0));
    @(posedge clk);
    #1;
    sif.s_valid = 1'b0;
  endtask

  task automatic wait_idle(output int c);
    int n = 0;
    @(negedge clk);
    while (sif.busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 66'(n >= 500), 66'(0));
    c = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_flags"}, 66'({sif.s_ready, sif.div_en, sif.m_valid, sif.m_div0, sif.m_last, sif.busy, sif.err_div0}), 66'(0));
    chk({tag, "_div_a"}, 66'(sif.div_a), 66'(0));
    chk({tag, "_div_b"}, 66'(sif.div_b), 66'(0));
    chk({tag, "_m_quot"}, 66'(sif.m_quotient), 66'(0));
  endtask

  initial begin
    int c, nmv, len;
    logic [31:0] d;
    sif.div_ld = 1'b0; sif.div_val = '0; sif.s_valid = 1'b0; sif.s_data = '0;
    sif.s_last = 1'b0; sif.m_ready = 1'b0;
    #12;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);
    // Basic vector: 9..12 / 3
    clear(); sif.m_ready = 1'b1;
    load(3);
    send(64'd9, 1'b0, 0); send(64'd10, 1'b0, 0); send(64'd11, 1'b0, 0); send(64'd12, 1'b1, 0);
    wait_idle(c);
    chk("basic_latency", 66'(first_mv - first_acc), 66'(LAT + 2));
    chk("basic_count", 66'(n_pop), 66'(4));
    chk("basic_b2b", 66'(popc_q[3] - popc_q[0]), 66'(3));
    chk("basic_last", 66'(n_last), 66'(1));
    chk("basic_busy_fall", 66'(c - last_pop), 66'(2));
    // Backpressure: 20 dividends with the consumer stalled
    clear(); sif.m_ready = 1'b0;
    load(1);
    fork
      for (int i = 1; i <= 20; i++) send(64'(i), i == 20, 0);
      begin
        tick(30);
        chk("bp_accepted", 66'(n_acc), 66'(DEPTH));
        chk("bp_s_ready", 66'(sif.s_ready), 66'(0));
        sif.m_ready = 1'b1;
      end
    join
    wait_idle(c);
    chk("bp_count", 66'(n_pop), 66'(20));
    chk("bp_last", 66'(n_last), 66'(1));
    chk("bp_credit", 66'(outst_max <= DEPTH), 66'(1));
    // Zero divisor
    clear();
    load(0);
    send({$urandom, $urandom}, 1'b0, 0); send({$urandom, $urandom}, 1'b1, 0);
    wait_idle(c);
    chk("d0_err", 66'(sif.err_div0), 66'(1));
    chk("d0_count", 66'(n_pop), 66'(2));
    // div_ld while running is ignored
    clear();
    load(5);
    send(64'd10, 1'b0, 0);
    sif.div_ld = 1'b1; sif.div_val = 32'd7;
    tick(1);
    sif.div_ld = 1'b0;
    chk("ldrun_div_b", 66'(sif.div_b), 66'(5));
    send(64'd35, 1'b1, 0);
    wait_idle(c);
    chk("ldrun_count", 66'(n_pop), 66'(2));
    chk("err_sticky", 66'(sif.err_div0), 66'(1));
    // Reset with 3 in flight and 2 queued
    clear(); sif.m_ready = 1'b0;
    load(9);
    for (int i = 0; i < 5; i++) send({$urandom, $urandom}, 1'b0, 0);
    tick(2);
    chk("prerst_m_valid", 66'(sif.m_valid), 66'(1));
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk_reset_outputs("midrst");
    tick(1);
    rst_n = 1'b1;
    sif.m_ready = 1'b1;
    nmv = 0;
    repeat (10) begin
      @(negedge clk);
      if (sif.m_valid) nmv++;
    end
    chk("postrst_m_valid", 66'(nmv), 66'(0));
    chk("postrst_busy", 66'(sif.busy), 66'(0));
    tick(1);
    // Back-to-back random vectors, first one three beats long
    for (int v = 0; v < 8; v++) begin
      len = v == 0 ? 3 : int'($urandom_range(1, 12));
      d = v[0] ? 32'($urandom_range(1, 100)) : $urandom;
      if (d == 32'd0) d = 32'd1;
      clear();
      rnd_ready = v > 1;
      load(d);
      for (int i = 0; i < len; i++) send({$urandom, $urandom}, i == len - 1, v > 1 ? int'($urandom_range(0, 2)) : 0);
      wait_idle(c);
      rnd_ready = 1'b0;
      sif.m_ready = 1'b1;
      chk("vec_count", 66'(n_pop), 66'(len));
      chk("vec_last", 66'(n_last), 66'(1));
      chk("vec_credit", 66'(outst_max <= DEPTH), 66'(1));
    end
    chk("sb_empty", 66'(exp_q.size()), 66'(0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
